// File: rtl/fir_coeff_loader.sv
// Coefficient write-side loader for the FIR: shadow bank fill from a valid/ready stream, burst-length
// checking, and swap-gated commit to the active bank. Define FIR_COEFF_SYMMETRIC_EN for half-length mirrored bursts.
module fir_coeff_loader #(
  parameter int              NTAPS    = 33,
  parameter int              CW       = 16,
  parameter logic [CW-1:0]   TAP0_RST = 16'h7FFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [CW-1:0]         wr_data,
  input  logic                  wr_last,
  input  logic                  swap_ok,
  output logic [NTAPS*CW-1:0]   coeff_flat,
  output logic                  commit_done,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int IW = $clog2(NTAPS) + 1;
`ifdef FIR_COEFF_SYMMETRIC_EN
  localparam int N_EXP = (NTAPS + 1) / 2;
`else
  localparam int N_EXP = NTAPS;
`endif
  localparam logic [IW-1:0] LAST_POS = IW'(N_EXP - 1);
  localparam logic [IW-1:0] ONE      = IW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    PEND  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic accept;
  logic shadow_we;
  logic err_set;
  logic commit;
  logic [NTAPS-1:0] hit;

  logic signed [CW-1:0] shadow [NTAPS];
  logic signed [CW-1:0] active [NTAPS];

  function automatic logic signed [CW-1:0] tap_rst(input int k);
    return (k == 0) ? TAP0_RST : '0;
  endfunction

  // Beat position tracking; idx is always 0 in IDLE, so IDLE and LOAD share one path.
  always_comb begin
    accept    = wr_valid && wr_ready;
    state_nxt = state;
    idx_nxt   = idx;
    shadow_we = 1'b0;
    err_set   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          shadow_we = 1'b1;
          idx_nxt   = idx + ONE;
          if (wr_last) begin
            if (idx == LAST_POS) begin
              state_nxt = PEND;
            end else begin
              err_set   = 1'b1;
              idx_nxt   = '0;
              state_nxt = IDLE;
            end
          end else if (idx == LAST_POS) begin
            err_set   = 1'b1;
            state_nxt = DRAIN;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      DRAIN: begin
        if (accept && wr_last) begin
          idx_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      PEND: begin
        if (swap_ok) begin
          commit    = 1'b1;
          idx_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Tap select for the shadow write; the mirrored form lands each beat on both ends.
`ifdef FIR_COEFF_SYMMETRIC_EN
  localparam logic [IW-1:0] LAST_TAP = IW'(NTAPS - 1);
  logic [IW-1:0] mirror;
  assign mirror = LAST_TAP - idx;
  always_comb begin
    hit = '0;
    for (int k = 0; k < NTAPS; k++) begin
      hit[k] = (IW'(k) == idx) || (IW'(k) == mirror);
    end
  end
`else
  always_comb begin
    hit = '0;
    for (int k = 0; k < NTAPS; k++) begin
      hit[k] = (IW'(k) == idx);
    end
  end
`endif

  // Control registers; ready/busy are registered images of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      wr_ready    <= 1'b1;
      busy        <= 1'b0;
      commit_done <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      wr_ready    <= (state_nxt != PEND);
      busy        <= (state_nxt != IDLE);
      commit_done <= commit;
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  // Shadow and active banks; both carry the impulse reset so a reset drops any pending set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow[k] <= tap_rst(k);
        active[k] <= tap_rst(k);
      end
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        if (shadow_we && hit[k]) begin
          shadow[k] <= wr_data;
        end
        if (commit) begin
          active[k] <= shadow[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_flat
    assign coeff_flat[CW*k +: CW] = active[k];
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader, checked against a burst-level model of the active coefficient set.
module tb_fir_coeff_loader;
  localparam int NTAPS = 33;
  localparam int CW    = 16;
`ifdef FIR_COEFF_SYMMETRIC_EN
  localparam int NEXP = (NTAPS + 1) / 2;
`else
  localparam int NEXP = NTAPS;
`endif
  localparam int SHORT_N = NEXP - 13;
  localparam int LONG_N  = NEXP + 7;

  logic clk, rst;
  logic wr_valid, wr_ready, wr_last, swap_ok, commit_done, busy, err, err_clr;
  logic [CW-1:0] wr_data;
  logic [NTAPS*CW-1:0] coeff_flat;

  int checks = 0;
  int passes = 0;
  logic [CW-1:0] burst_data [64];
  logic [CW-1:0] exp_tap [NTAPS];
  int err_beat, commit_cnt, ready_miss;

  fir_coeff_loader #(.NTAPS(NTAPS), .CW(CW), .TAP0_RST(16'h7FFF)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .swap_ok(swap_ok), .coeff_flat(coeff_flat), .commit_done(commit_done),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NTAPS*CW-1:0] exp_flat();
    logic [NTAPS*CW-1:0] f;
    f = '0;
    for (int k = 0; k < NTAPS; k++) f[CW*k +: CW] = exp_tap[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) exp_tap[k] = (k == 0) ? 16'h7FFF : 16'h0000;
  endtask

  // A good burst of NEXP beats becomes the full tap set; mirrored mode folds the upper half.
  task automatic model_commit();
    for (int k = 0; k < NTAPS; k++) begin
      int src;
      src = k;
`ifdef FIR_COEFF_SYMMETRIC_EN
      if (k >= NEXP) src = NTAPS - 1 - k;
`endif
      exp_tap[k] = burst_data[src];
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) burst_data[i] = CW'($urandom);
  endtask

  task automatic drive_burst(input int n, input bit gaps, input bit with_last);
    err_beat = -1;
    commit_cnt = 0;
    ready_miss = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          wr_valid = 1'b0;
          @(posedge clk); #1;
          if (commit_done) commit_cnt++;
        end
      end
      wr_valid = 1'b1;
      wr_data  = burst_data[i];
      wr_last  = with_last && (i == n - 1);
      if (!wr_ready) ready_miss++;
      @(posedge clk); #1;
      if (err && err_beat < 0) err_beat = i;
      if (commit_done) commit_cnt++;
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0; swap_ok = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (coeff_flat !== exp_flat()) $display("FAIL reset_coeff: got %h want %h", coeff_flat, exp_flat()); else passes++;
    checks++; if (wr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", wr_ready); else passes++;
    checks++; if ({busy, err, commit_done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, err, commit_done}); else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (coeff_flat[CW-1:0] !== 16'h7FFF) $display("FAIL reset_tap0: got %h want 7fff", coeff_flat[CW-1:0]); else passes++;
    checks++; if (coeff_flat[NTAPS*CW-1:CW] !== '0) $display("FAIL reset_upper_taps: got %h want 0", coeff_flat[NTAPS*CW-1:CW]); else passes++;
  endtask

  task automatic test_fast_load();
    for (int k = 0; k < NEXP; k++) burst_data[k] = CW'(16'h0100 + k);
    swap_ok = 1'b1;
    drive_burst(NEXP, 1'b0, 1'b1);
    checks++; if (busy !== 1'b1) $display("FAIL fast_busy_pend: got %b want 1", busy); else passes++;
    checks++; if (coeff_flat !== exp_flat()) $display("FAIL fast_coeff_before: got %h want %h", coeff_flat, exp_flat()); else passes++;
    model_commit();
    @(posedge clk); #1;
    checks++; if (commit_done !== 1'b1) $display("FAIL fast_commit_pulse: got %b want 1", commit_done); else passes++;
    checks++; if (coeff_flat !== exp_flat()) $display("FAIL fast_coeff_after: got %h want %h", coeff_flat, exp_flat()); else passes++;
    checks++; if (wr_ready !== 1'b1) $display("FAIL fast_ready_after: got %b want 1", wr_ready); else passes++;
    @(posedge clk); #1;
    checks++; if ({commit_done, busy} !== 2'b00) $display("FAIL fast_idle_after: got %b want 00", {commit_done, busy}); else passes++;
    swap_ok = 1'b0;
  endtask

  task automatic test_pend_hold();
    int bad;
    fill_random(NEXP);
    swap_ok = 1'b0;
    drive_burst(NEXP, 1'b1, 1'b1);
    bad = 0;
    repeat (10) begin
      wr_valid = 1'b1;
      wr_data  = CW'($urandom);
      wr_last  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (wr_ready !== 1'b0 || busy !== 1'b1 || commit_done !== 1'b0 || coeff_flat !== exp_flat()) bad++;
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    checks++; if (bad !== 0) $display("FAIL pend_hold_cycles: got %0d bad cycles want 0", bad); else passes++;
    checks++; if (wr_ready !== 1'b0) $display("FAIL pend_ready: got %b want 0", wr_ready); else passes++;
    swap_ok = 1'b1;
    model_commit();
    @(posedge clk); #1;
    swap_ok = 1'b0;
    checks++; if (commit_done !== 1'b1) $display("FAIL pend_commit_pulse: got %b want 1", commit_done); else passes++;
    checks++; if (coeff_flat !== exp_flat()) $display("FAIL pend_coeff: got %h want %h", coeff_flat, exp_flat()); else passes++;
    @(posedge clk); #1;
    checks++; if ({commit_done, busy} !== 2'b00) $display("FAIL pend_after: got %b want 00", {commit_done, busy}); else passes++;
  endtask

  task automatic test_short_burst();
    fill_random(SHORT_N);
    swap_ok = 1'b1;
    drive_burst(SHORT_N, 1'b1, 1'b1);
    checks++; if (err_beat !== SHORT_N - 1) $display("FAIL short_err_beat: got %0d want %0d", err_beat, SHORT_N - 1); else passes++;
    checks++; if ({err, busy} !== 2'b10) $display("FAIL short_err_idle: got %b want 10", {err, busy}); else passes++;
    @(posedge clk); #1;
    checks++; if (commit_done !== 1'b0 || commit_cnt !== 0) $display("FAIL short_no_commit: got %b/%0d want 0/0", commit_done, commit_cnt); else passes++;
    checks++; if (coeff_flat !== exp_flat()) $display("FAIL short_coeff_kept: got %h want %h", coeff_flat, exp_flat()); else passes++;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) $display("FAIL short_err_clr: got %b want 0", err); else passes++;
    fill_random(NEXP);
    drive_burst(NEXP, 1'b0, 1'b1);
    model_commit();
    @(posedge clk); #1;
    checks++; if (commit_done !== 1'b1 || coeff_flat !== exp_flat()) $display("FAIL short_recover: got %b %h want 1 %h", commit_done, coeff_flat, exp_flat()); else passes++;
    swap_ok = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_long_burst();
    int seen;
    fill_random(LONG_N);
    swap_ok = 1'b1;
    drive_burst(LONG_N, 1'b0, 1'b1);
    checks++; if (err_beat !== NEXP - 1) $display("FAIL long_err_beat: got %0d want %0d", err_beat, NEXP - 1); else passes++;
    checks++; if (ready_miss !== 0) $display("FAIL long_ready_drain: got %0d stalls want 0", ready_miss); else passes++;
    checks++; if ({err, busy} !== 2'b10) $display("FAIL long_err_idle: got %b want 10", {err, busy}); else passes++;
    seen = commit_cnt;
    repeat (3) begin
      @(posedge clk); #1;
      if (commit_done) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL long_no_commit: got %0d pulses want 0", seen); else passes++;
    checks++; if (coeff_flat !== exp_flat()) $display("FAIL long_coeff_kept: got %h want %h", coeff_flat, exp_flat()); else passes++;
    fill_random(NEXP);
    drive_burst(NEXP, 1'b0, 1'b1);
    model_commit();
    @(posedge clk); #1;
    checks++; if (commit_done !== 1'b1 || coeff_flat !== exp_flat()) $display("FAIL long_recover: got %b %h want 1 %h", commit_done, coeff_flat, exp_flat()); else passes++;
    swap_ok = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    fill_random(NEXP);
    swap_ok = 1'b1;
    drive_burst(15, 1'b0, 1'b0);
    wr_valid = 1'b1;
    wr_data  = burst_data[15];
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++; if (coeff_flat !== exp_flat()) $display("FAIL rstmid_coeff: got %h want %h", coeff_flat, exp_flat()); else passes++;
    checks++; if ({wr_ready, busy, err, commit_done} !== 4'b1000) $display("FAIL rstmid_flags: got %b want 1000", {wr_ready, busy, err, commit_done}); else passes++;
    wr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy, commit_done} !== 2'b00 || coeff_flat !== exp_flat()) $display("FAIL rstmid_after: got %b %h want 00 %h", {busy, commit_done}, coeff_flat, exp_flat()); else passes++;
    swap_ok = 1'b0;
  endtask

  task automatic test_reset_in_pend();
    int seen;
    fill_random(NEXP);
    swap_ok = 1'b1;
    drive_burst(NEXP, 1'b0, 1'b1);
    model_commit();
    @(posedge clk); #1;
    swap_ok = 1'b0;
    fill_random(NEXP);
    drive_burst(NEXP, 1'b0, 1'b1);
    checks++; if (busy !== 1'b1 || coeff_flat !== exp_flat()) $display("FAIL rstpend_pending: got %b %h want 1 %h", busy, coeff_flat, exp_flat()); else passes++;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++; if (coeff_flat !== exp_flat()) $display("FAIL rstpend_coeff: got %h want %h", coeff_flat, exp_flat()); else passes++;
    checks++; if ({wr_ready, busy, commit_done} !== 3'b100) $display("FAIL rstpend_flags: got %b want 100", {wr_ready, busy, commit_done}); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    swap_ok = 1'b1;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (commit_done || coeff_flat !== exp_flat()) seen++;
    end
    swap_ok = 1'b0;
    checks++; if (seen !== 0) $display("FAIL rstpend_discarded: got %0d bad cycles want 0", seen); else passes++;
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 4; b++) begin
      fill_random(NEXP);
      swap_ok = (b < 2);
      drive_burst(NEXP, b[0], 1'b1);
      checks++; if (busy !== 1'b1 || commit_cnt !== 0) $display("FAIL b2b_pend_%0d: got %b/%0d want 1/0", b, busy, commit_cnt); else passes++;
      if (b >= 2) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        swap_ok = 1'b1;
      end
      model_commit();
      @(posedge clk); #1;
      checks++; if (commit_done !== 1'b1 || coeff_flat !== exp_flat()) $display("FAIL b2b_commit_%0d: got %b %h want 1 %h", b, commit_done, coeff_flat, exp_flat()); else passes++;
    end
    swap_ok = 1'b0;
    @(posedge clk); #1;
    checks++; if ({commit_done, busy, err} !== 3'b000) $display("FAIL b2b_end: got %b want 000", {commit_done, busy, err}); else passes++;
  endtask

`ifdef FIR_COEFF_SYMMETRIC_EN
  task automatic test_symmetric();
    int bad;
    for (int k = 0; k < NEXP; k++) burst_data[k] = CW'(k + 1);
    swap_ok = 1'b1;
    drive_burst(NEXP, 1'b0, 1'b1);
    @(posedge clk); #1;
    bad = 0;
    for (int k = 0; k < NEXP; k++) begin
      if (coeff_flat[CW*k +: CW] !== CW'(k + 1)) bad++;
      if (coeff_flat[CW*(NTAPS-1-k) +: CW] !== CW'(k + 1)) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL sym_mirror: got %0d bad taps want 0", bad); else passes++;
    checks++; if (coeff_flat[CW*(NEXP-1) +: CW] !== CW'(NEXP)) $display("FAIL sym_centre: got %h want %h", coeff_flat[CW*(NEXP-1) +: CW], CW'(NEXP)); else passes++;
    model_commit();
    swap_ok = 1'b0;
    fill_random(NTAPS);
    drive_burst(NTAPS, 1'b0, 1'b1);
    checks++; if (err !== 1'b1 || commit_cnt !== 0) $display("FAIL sym_full_burst_err: got %b/%0d want 1/0", err, commit_cnt); else passes++;
    checks++; if (coeff_flat !== exp_flat()) $display("FAIL sym_coeff_kept: got %h want %h", coeff_flat, exp_flat()); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_fast_load();
    test_pend_hold();
    test_short_burst();
    test_long_burst();
    test_reset_mid_burst();
    test_reset_in_pend();
    test_back_to_back();
`ifdef FIR_COEFF_SYMMETRIC_EN
    test_symmetric();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient write-side front end for the 33-tap FIR filter. It accepts a valid/ready stream of 16-bit coefficients from the host register path (PCIe/DMA control plane) into a shadow bank, checks the burst length, and presents a registered, double-buffered coefficient vector to the filter's coefficient ports. A new set becomes active only on a caller-supplied swap strike, so the filter never sees a half-updated set.

## Interface
- NTAPS, 33, number of filter taps (≥2)
- CW, 16, coefficient width in bits
- TAP0_RST, 16'h7FFF, reset value of active/shadow tap 0; all other taps reset to 0 (pass-through impulse)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_valid  in  1  coefficient beat valid
- wr_ready  out  1  loader can accept a beat
- wr_data  in  CW  coefficient value, two's complement, passed through unaltered
- wr_last  in  1  final beat of a burst
- swap_ok  in  1  filter-side safe point; commits a pending set
- coeff_flat  out  NTAPS*CW  active coefficients, tap k at [CW*k+CW-1 : CW*k]
- commit_done  out  1  one-cycle pulse, coincident with first cycle of new coeff_flat
- busy  out  1  high in LOAD, DRAIN or PEND
- err  out  1  sticky burst-length error
- err_clr  in  1  clears err

## Operation
- Expected beats per burst N_EXP = NTAPS (or ceil(NTAPS/2), see Configuration). Beat counter idx, width clog2(NTAPS)+1.
- States: IDLE, LOAD, DRAIN, PEND. Beat accepted when wr_valid && wr_ready.
- wr_ready = 1 in IDLE, LOAD, DRAIN; 0 in PEND.
- IDLE: accepted beat writes shadow[0], idx<=1, -> LOAD. If that beat has wr_last and N_EXP>1: error, idx<=0, stay IDLE.
- LOAD: accepted beat writes shadow[idx], idx++.
  - wr_last with idx==N_EXP-1: -> PEND.
  - wr_last with idx<N_EXP-1: short burst, err<=1, idx<=0, -> IDLE.
  - no wr_last with idx==N_EXP-1: long burst, beat written, err<=1, -> DRAIN.
- DRAIN: beats accepted and discarded; accepted wr_last -> IDLE, idx<=0.
- PEND: swap_ok high -> active<=shadow, commit_done pulse, idx<=0, -> IDLE. swap_ok in any other state is ignored.
- Failed bursts never reach the active bank; shadow keeps partial contents and is fully overwritten by the next good burst.
- err_clr and a new error in the same cycle: set wins. err_clr does not affect the state machine.
- No arithmetic on data; values copied bit-exact.

## Timing
- All outputs registered. Reset values: wr_ready=1, coeff_flat = {0,...,0,TAP0_RST}, commit_done=0, busy=0, err=0; state IDLE, idx=0, shadow = active reset values.
- Latency: last beat accepted at edge N -> PEND from N; wr_ready low from cycle after N. swap_ok sampled high at edge M>N -> coeff_flat and commit_done change at M; commit_done low at M+1; wr_ready high at M.
- Fastest load-to-active: N_EXP beats + 1 cycle (swap_ok already high).
- Back-to-back beats at one per clock, no bubbles, in IDLE/LOAD/DRAIN.
- Reset mid-burst or in PEND: immediate return to reset values; pending set discarded.

## Configuration
- FIR_COEFF_SYMMETRIC_EN defined: N_EXP = ceil(NTAPS/2) (17); beat k writes shadow[k] and shadow[NTAPS-1-k] (centre tap once). Linear-phase filters only.
- Not defined: N_EXP = NTAPS (33); beat k writes shadow[k] only.

## Test plan
- After reset: coeff_flat tap0=16'h7FFF, taps1..32=0, wr_ready=1, err=0; send 33 beats k=0..32 data=16'h0100+k, last on beat 32, swap_ok held high -> coeff_flat tap k=16'h0100+k, commit_done one pulse on the cycle after the last beat, busy low afterwards.
- Load 33 beats with swap_ok low for 10 cycles -> coeff_flat unchanged, wr_ready=0, busy=1; then swap_ok pulse -> new set active, commit_done single pulse.
- Short burst: 20 beats, last on beat 19 -> err=1, coeff_flat unchanged, IDLE; assert err_clr -> err=0; next good burst commits normally.
- Long burst: 40 beats, last on beat 39 -> err=1 at beat 32, beats 33..39 accepted and discarded, no commit; next good burst values active after swap.
- Async rst asserted at beat 15 of a burst and while in PEND -> outputs return to reset values immediately; no commit_done.
- FIR_COEFF_SYMMETRIC_EN: 17 beats data=k+1 -> tap k and tap 32-k both =k+1, tap 16=17; a 33-beat burst -> err=1.
